// File: rtl/aes_key_expand_seq_pkg.sv
// -----------------------------------------------------------------------------
// aes_key_expand_seq_pkg
// Shared AES-128 definitions for the key-schedule engine and its SubWord lanes.
//   AES_NR / AES_NK  : round count and key length in 32-bit words for AES-128
//   aes_word_t       : one 32-bit key-schedule word
//   aes_rkey_t       : one 128-bit round key {w0,w1,w2,w3}
//   RCON_INIT        : round constant used when computing round key 1
//   ks_state_e       : key-schedule FSM states
//   xtime()          : multiply-by-x in GF(2^8) (also used by MixColumns)
//   sbox()           : forward AES S-box lookup
// -----------------------------------------------------------------------------
package aes_key_expand_seq_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_rkey_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1; 0x80 wraps to 0x1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_subword.sv
// -----------------------------------------------------------------------------
// S_Opp_Basic2
// SubWord: four independent, purely combinational S-box lanes, one per byte.
//   word_i : 32-bit input word
//   word_o : 32-bit word with every byte substituted through the AES S-box
// -----------------------------------------------------------------------------
module S_Opp_Basic2
  import aes_key_expand_seq_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_o[gi*8 +: 8] = sbox(word_i[gi*8 +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// -----------------------------------------------------------------------------
// aes_key_expand_seq
// Iterative AES-128 key schedule: loads a cipher key on start and presents the
// round keys 0..NR one per accepted valid/ready beat, then pulses done.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : load key_in and begin expansion (only acted on while idle)
//   key_in    : cipher key, w0 = key_in[127:96]
//   rk_ready  : consumer accepts rk_out this cycle
//   busy      : expansion in progress
//   rk_valid  : rk_out / rk_round carry a valid round key
//   rk_round  : index of the round key on rk_out
//   rk_out    : round key {w0,w1,w2,w3}
//   done      : one-cycle pulse after the final round key is accepted
// NR must be 10 (AES-128); the schedule recurrence below assumes Nk = 4.
// -----------------------------------------------------------------------------
module aes_key_expand_seq
  import aes_key_expand_seq_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       key_in,
  input  logic               rk_ready,
  output logic               busy,
  output logic               rk_valid,
  output logic [ROUND_W-1:0] rk_round,
  output logic [127:0]       rk_out,
  output logic               done
);

  ks_state_e          state_q;
  aes_rkey_t          key_q;
  logic [ROUND_W-1:0] round_q;
  logic [7:0]         rcon_q;
  logic               busy_q;
  logic               valid_q;
  logic               done_q;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_w3, sub_w3, temp;
  aes_rkey_t key_d;
  logic      last_round;

  assign {w0, w1, w2, w3} = key_q;

  // RotWord: [a0 a1 a2 a3] -> [a1 a2 a3 a0], a0 being the top byte.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  S_Opp_Basic2 u_subword (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  assign temp = sub_w3 ^ {rcon_q, 24'h000000};

  // XOR chain: each new word folds in the freshly computed word before it.
  always_comb begin
    key_d[127:96] = w0 ^ temp;
    key_d[95:64]  = w1 ^ key_d[127:96];
    key_d[63:32]  = w2 ^ key_d[95:64];
    key_d[31:0]   = w3 ^ key_d[63:32];
  end

  assign last_round = (round_q == ROUND_W'(NR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_EMIT;
            key_q   <= key_in;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          // Output is held untouched until the consumer takes it.
          if (rk_ready) begin
            if (last_round) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q   <= key_d;
              round_q <= round_q + ROUND_W'(1);
              rcon_q  <= xtime(rcon_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_round = round_q;
  assign rk_out   = key_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.NR(10), .ROUND_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_m   [256];
  logic [127:0] exp_keys [11];
  logic [127:0] obs_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- reference model (field arithmetic from first principles)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(v), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one expansion from a negedge. stall_a/stall_b: rounds where ready is
  // withheld for 3 cycles. restart_round: round during which start is pulsed
  // with a different key. start_next: start a new key on the done cycle.
  task automatic expand(input logic [127:0] key, input bit do_start,
                        input int stall_a, input int stall_b, input int restart_round,
                        input bit start_next, input logic [127:0] next_key);
    int beat, stalls, stall_total, cyc, guard;
    bit accept;
    model(key);
    if (do_start) begin
      start  = 1'b1;
      key_in = key;
      @(negedge clk);
      start  = 1'b0;
      key_in = $urandom();
    end
    cyc = 1; beat = 0; stalls = 0; stall_total = 0; guard = 0;
    while (beat <= 10 && guard < 200) begin
      check($sformatf("r%0d_valid", beat), 128'(rk_valid), 128'd1);
      check($sformatf("r%0d_busy", beat), 128'(busy), 128'd1);
      check($sformatf("r%0d_done", beat), 128'(done), 128'd0);
      check($sformatf("r%0d_round", beat), 128'(rk_round), 128'(beat));
      check($sformatf("r%0d_key", beat), rk_out, exp_keys[beat]);
      obs_keys[beat] = rk_out;
      if ((beat == stall_a || beat == stall_b) && stalls < 3) begin
        rk_ready = 1'b0; accept = 1'b0; stalls++; stall_total++;
      end else begin
        rk_ready = 1'b1; accept = 1'b1;
      end
      start  = (beat == restart_round);
      key_in = (beat == restart_round) ? ~key : key_in;
      @(negedge clk);
      cyc++; guard++;
      if (accept) begin beat++; stalls = 0; end
    end
    start    = 1'b0;
    rk_ready = 1'($urandom_range(0, 1));
    if (guard >= 200) begin
      n_checks++; n_errors++;
      $error("FAIL expand_timeout observed=%0d expected<200", guard);
    end
    check("done_pulse", 128'(done), 128'd1);
    check("done_busy", 128'(busy), 128'd0);
    check("done_valid", 128'(rk_valid), 128'd0);
    check("done_round", 128'(rk_round), 128'd10);
    check("done_key_hold", rk_out, exp_keys[10]);
    check("done_latency", 128'(cyc), 128'(12 + stall_total));
    if (start_next) begin
      start  = 1'b1;
      key_in = next_key;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 128'(done), 128'd0);
    $display("expansion key=%h stalls=%0d cycles=%0d last=%h", key, stall_total, cyc, obs_keys[10]);
  endtask

  initial begin
    int g;
    logic [127:0] ka, kb;
    build_sbox();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_round", 128'(rk_round), 128'd0);
    check("rst_key", rk_out, 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", 128'(rk_valid), 128'd0);

    // FIPS-197 vector, ready always high
    expand(FIPS_KEY, 1'b1, -1, -1, -1, 1'b0, '0);
    check("fips_r0", obs_keys[0], FIPS_KEY);
    check("fips_r1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r2", obs_keys[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("fips_r10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Backpressure at rounds 4 and 10
    expand(FIPS_KEY, 1'b1, 4, 10, -1, 1'b0, '0);
    check("bp_r10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Start while busy must be ignored
    expand(FIPS_KEY, 1'b1, -1, -1, 5, 1'b0, '0);
    check("sb_r10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of an expansion
    start = 1'b1; key_in = FIPS_KEY;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b1; g = 0;
    while (rk_round != 4'd7 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin
      n_checks++; n_errors++;
      $error("FAIL reach_round7 observed=%0d expected=7", rk_round);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_valid", 128'(rk_valid), 128'd0);
    check("mid_rst_round", 128'(rk_round), 128'd0);
    check("mid_rst_key", rk_out, 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 128'(done), 128'd0);
    end
    expand(SEQ_KEY, 1'b1, -1, -1, -1, 1'b0, '0);
    check("seq_r1", obs_keys[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    // All-zero key exercises rcon 80 -> 1b -> 36
    expand(128'd0, 1'b1, 8, -1, -1, 1'b0, '0);

    // Start coincident with done, then the chained expansion
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(ka, 1'b1, -1, -1, -1, 1'b1, kb);
    expand(kb, 1'b0, -1, -1, -1, 1'b0, '0);

    // Random keys with random stall points
    for (int k = 0; k < 4; k++) begin
      ka = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(ka, 1'b1, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
             int'($urandom_range(0, 10)), 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
